// File: rtl/ram_share_arbiter.sv
// Shares the core's work-RAM hiscore port between two background requesters,
// pausing the CPU and letting it settle before each round-robin grant.
module ram_share_arbiter #(
  parameter int ADDR_W = 14,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              pause_user,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [7:0]        req_wdata0,
  input  logic [7:0]        req_wdata1,
  input  logic [1:0]        req_we,
  output logic [1:0]        grant,
  output logic              pause_cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              ram_access,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        req_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_SETTLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_reg, state_next;
  logic       winner_reg, winner_next;
  logic       rr_last_reg, rr_last_next;
  logic [3:0] settle_cnt_reg, settle_cnt_next;

  always_comb begin
    state_next      = state_reg;
    winner_next     = winner_reg;
    rr_last_next    = rr_last_reg;
    settle_cnt_next = settle_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (|req) begin
          state_next  = S_PAUSE;
          winner_next = (&req) ? ~rr_last_reg : req[1];
        end
      end
      S_PAUSE: begin
        settle_cnt_next = 4'd0;
        state_next      = S_SETTLE;
      end
      S_SETTLE: begin
        // A requester that gives up while the CPU settles never sees a grant.
        if (!req[winner_reg]) begin
          state_next = S_RELEASE;
        end else if (ce) begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_next = S_GRANT;
          end else begin
            settle_cnt_next = settle_cnt_reg + 4'd1;
          end
        end
      end
      S_GRANT: begin
        if (!req[winner_reg]) begin
          state_next   = S_RELEASE;
          rr_last_next = winner_reg;
        end
      end
      S_RELEASE: begin
        // CPU is still paused, so the waiting side is served without re-settling.
        if (req[~winner_reg]) begin
          winner_next = ~winner_reg;
          state_next  = S_GRANT;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      winner_reg     <= 1'b0;
      rr_last_reg    <= 1'b1;
      settle_cnt_reg <= 4'd0;
      grant          <= 2'b00;
      ram_access     <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= 8'd0;
    end else begin
      state_reg      <= state_next;
      winner_reg     <= winner_next;
      rr_last_reg    <= rr_last_next;
      settle_cnt_reg <= settle_cnt_next;
      // Port outputs follow the granted requester with one cycle of lag.
      if (state_next == S_GRANT) begin
        grant      <= winner_next ? 2'b10 : 2'b01;
        ram_access <= 1'b1;
        ram_we     <= req_we[winner_next];
        ram_addr   <= winner_next ? req_addr1 : req_addr0;
        ram_wdata  <= winner_next ? req_wdata1 : req_wdata0;
      end else begin
        grant      <= 2'b00;
        ram_access <= 1'b0;
        ram_we     <= 1'b0;
      end
    end
  end

  assign pause_cpu = pause_user | (state_reg != S_IDLE);
  assign req_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_share_arbiter.sv
// Directed bench for ram_share_arbiter: reset, settle latency, handover,
// round-robin ties, abort during settle and reset while granted.
module tb_ram_share_arbiter;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ce;
  logic              pause_user;
  logic [1:0]        req;
  logic [ADDR_W-1:0] req_addr0, req_addr1;
  logic [7:0]        req_wdata0, req_wdata1;
  logic [1:0]        req_we;
  logic [1:0]        grant;
  logic              pause_cpu;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic              ram_access;
  logic [7:0]        ram_rdata;
  logic [7:0]        req_rdata;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  ram_share_arbiter #(.ADDR_W(ADDR_W), .SETTLE(4)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .pause_user(pause_user),
    .req(req), .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .req_we(req_we),
    .grant(grant), .pause_cpu(pause_cpu), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_access(ram_access),
    .ram_rdata(ram_rdata), .req_rdata(req_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
      $display("check %-16s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      $display("FAIL %-16s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock; ce runs at half rate and toggles just after each edge.
  task automatic tick();
    @(posedge clk);
    #1;
    ce = ~ce;
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp);
    for (int i = 0; i < 40 && grant == 2'b00; i++) tick();
    check(tag, 32'(grant), 32'(exp));
  endtask

  task automatic drop_all();
    req = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b0; pause_user = 1'b1; req = 2'b11;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = 8'd0; req_wdata1 = 8'd0;
    req_we = 2'b00; ram_rdata = 8'd0;

    // 1: reset with both requests pending
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_we", 32'(ram_we), 32'h0);
    check("rst_pause_usr1", 32'(pause_cpu), 32'h1);
    pause_user = 1'b0;
    #1;
    check("rst_pause_usr0", 32'(pause_cpu), 32'h0);
    reset_n = 1'b1; req = 2'b00;
    tick();

    // 2: single request, exact settle latency with ce on every second edge
    req_addr0 = 14'h1234; req_wdata0 = 8'hA5; req_we = 2'b01;
    ce = 1'b0; req = 2'b01;
    tick();
    check("t2_pause", 32'(pause_cpu), 32'h1);
    check("t2_nogrant_e1", 32'(grant), 32'h0);
    repeat (8) tick();
    check("t2_nogrant_e9", 32'(grant), 32'h0);
    tick();
    check("t2_grant", 32'(grant), 32'h1);
    check("t2_access", 32'(ram_access), 32'h1);
    check("t2_addr", 32'(ram_addr), 32'h1234);
    check("t2_wdata", 32'(ram_wdata), 32'hA5);
    check("t2_we", 32'(ram_we), 32'h1);
    req_addr0 = 14'h0ABC; req_we = 2'b00; ram_rdata = 8'h5A;
    #1;
    check("t2_rdata", 32'(req_rdata), 32'h5A);
    check("t2_addr_lag", 32'(ram_addr), 32'h1234);
    tick();
    check("t2_addr_new", 32'(ram_addr), 32'h0ABC);
    check("t2_we_off", 32'(ram_we), 32'h0);
    req = 2'b00;
    tick();
    check("t2_rel_grant", 32'(grant), 32'h0);
    check("t2_rel_pause", 32'(pause_cpu), 32'h1);
    tick();
    check("t2_idle_pause", 32'(pause_cpu), 32'h0);

    // 3: tie from reset, handover from RELEASE, ungranted write strobe ignored
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req_addr1 = 14'h2222; req_we = 2'b01; req = 2'b11;
    wait_grant("t3_first", 2'b01);
    req = 2'b10;
    tick();
    check("t3_rel_grant", 32'(grant), 32'h0);
    check("t3_rel_pause", 32'(pause_cpu), 32'h1);
    tick();
    check("t3_hand_grant", 32'(grant), 32'h2);
    check("t3_hand_we", 32'(ram_we), 32'h0);
    check("t3_hand_addr", 32'(ram_addr), 32'h2222);
    req = 2'b00;
    tick();
    check("t3_rel2_pause", 32'(pause_cpu), 32'h1);
    tick();
    check("t3_idle_pause", 32'(pause_cpu), 32'h0);
    req_we = 2'b00;

    // 4: round-robin ties
    req = 2'b11;
    wait_grant("t4_tie_rr1", 2'b01);
    drop_all();
    req = 2'b11;
    wait_grant("t4_after_req0", 2'b10);
    drop_all();
    req = 2'b10;
    wait_grant("t4_req1_only", 2'b10);
    drop_all();
    req = 2'b11;
    wait_grant("t4_after_req1", 2'b01);
    drop_all();

    // 5: requester gives up during settle
    ce = 1'b0; req = 2'b01;
    repeat (4) tick();
    check("t5_settle_acc", 32'(ram_access), 32'h0);
    req = 2'b00;
    tick();
    check("t5_rel_grant", 32'(grant), 32'h0);
    check("t5_rel_pause", 32'(pause_cpu), 32'h1);
    check("t5_rel_acc", 32'(ram_access), 32'h0);
    tick();
    check("t5_idle_pause", 32'(pause_cpu), 32'h0);
    check("t5_idle_acc", 32'(ram_access), 32'h0);

    // 6: reset while granted and writing
    req_we = 2'b01; req = 2'b01;
    wait_grant("t6_grant", 2'b01);
    check("t6_we_on", 32'(ram_we), 32'h1);
    reset_n = 1'b0;
    tick();
    check("t6_rst_we", 32'(ram_we), 32'h0);
    check("t6_rst_grant", 32'(grant), 32'h0);
    check("t6_rst_pause", 32'(pause_cpu), 32'h0);
    reset_n = 1'b1; req = 2'b00; req_we = 2'b00;
    tick();
    check("t6_idle_pause", 32'(pause_cpu), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
